// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and constants for serial_receiver
package serial_rx_pkg;

  localparam int DEFAULT_DW      = 32;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 64;

  // Calculator frame packing: result byte at the bottom, flag nibble at [27:24]
  localparam int RESULT_LSB = 0;
  localparam int RESULT_W   = 8;
  localparam int FLAG_LSB   = 24;
  localparam int FLAG_W     = 4;

  // Deserializer FSM state
  typedef logic [0:0] rx_state_t;
  localparam rx_state_t IDLE  = 1'b0;
  localparam rx_state_t SHIFT = 1'b1;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous show-ahead frame FIFO with registered occupancy flags
module rx_fifo
  import serial_rx_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Push,
  input  logic [DW-1:0]          PushData,
  input  logic                   Pop,
  output logic [DW-1:0]          HeadData,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Full,
  output logic                   Empty,
  output logic                   Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);
  localparam logic [AW:0] CNT_NEARFUL = (AW+1)'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push
  always_comb begin
    pop_ok  = Pop && !Empty;
    push_ok = Push && (!Full || pop_ok);
  end

  // Storage, pointers, occupancy and the drop pulse all move on the same edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
      Overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= PushData;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      Overflow <= Push && !push_ok;
      case ({push_ok, pop_ok})
        2'b10: begin
          Count <= Count + 1'b1;
          Empty <= 1'b0;
          Full  <= (Count == CNT_NEARFUL);
        end
        2'b01: begin
          Count <= Count - 1'b1;
          Full  <= 1'b0;
          Empty <= (Count == CNT_ONE);
        end
        default: ;
      endcase
    end
  end

  assign HeadData = mem[rd_ptr];

endmodule

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - MSB-first deserializer into a show-ahead FIFO; optional mid-frame timeout via SERIAL_RX_TIMEOUT_EN
module serial_receiver
  import serial_rx_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   SerIn,
  input  logic                   SerValid,
  input  logic                   RdEn,
  output logic [DW-1:0]          RxData,
  output logic [RESULT_W-1:0]    RxResult,
  output logic [FLAG_W-1:0]      RxFlag,
  output logic                   Empty,
  output logic                   Full,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   RxBusy,
  output logic                   Overflow,
  output logic                   FrameErr
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DW - 1);

  rx_state_t     state;
  logic [DW-1:0] shreg;
  logic [DW-1:0] shift_next;
  logic [DW:0]   shift_ext;
  logic [CW-1:0] bit_cnt;
  logic          frame_done;
  logic          unused_msb;

  // The bit shifted out of the top is never needed; the concatenation keeps DW=1 legal
  assign shift_ext  = {shreg, SerIn};
  assign shift_next = shift_ext[DW-1:0];
  assign unused_msb = shift_ext[DW];

  // bit_cnt is 0 in IDLE, so one compare covers both the DW=1 and the SHIFT completion case
  assign frame_done = SerValid && (bit_cnt == LAST_IDX);
  assign RxBusy     = (state == SHIFT);

`ifdef SERIAL_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;

  // Abort on the idle cycle that brings the count to TIMEOUT; a valid bit always wins
  assign timeout_hit = (state == SHIFT) && !SerValid && (idle_cnt == TO_LAST);

  // Idle cycle counter and the abort pulse
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idle_cnt <= '0;
      FrameErr <= 1'b0;
    end else begin
      FrameErr <= timeout_hit;
      if (state != SHIFT || SerValid || timeout_hit) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign FrameErr       = 1'b0;
`endif

  // Deserializer FSM: accumulate bits, hand the completed word to the FIFO
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (SerValid) begin
      shreg <= shift_next;
      if (frame_done) begin
        bit_cnt <= '0;
        state   <= IDLE;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        state   <= SHIFT;
      end
    end
`ifdef SERIAL_RX_TIMEOUT_EN
    else if (timeout_hit) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end
`endif
  end

  rx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .Push     (frame_done),
    .PushData (shift_next),
    .Pop      (RdEn),
    .HeadData (RxData),
    .Count    (Count),
    .Full     (Full),
    .Empty    (Empty),
    .Overflow (Overflow)
  );

  assign RxResult = RxData[RESULT_LSB +: RESULT_W];
  assign RxFlag   = RxData[FLAG_LSB +: FLAG_W];

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - self-checking bench for serial_receiver (timeout checks follow SERIAL_RX_TIMEOUT_EN)
module tb_serial_receiver;

  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        SerIn;
  logic        SerValid;
  logic        RdEn;
  logic [31:0] RxData;
  logic [7:0]  RxResult;
  logic [3:0]  RxFlag;
  logic        Empty;
  logic        Full;
  logic [2:0]  Count;
  logic        RxBusy;
  logic        Overflow;
  logic        FrameErr;

  int n_pass  = 0;
  int n_total = 0;
  int busy_err;

  typedef struct {
    logic [31:0] frame;
    int          gap;
    logic [7:0]  exp_result;
    logic [3:0]  exp_flag;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] fr[5];

  always #5 Clk = ~Clk;

  serial_receiver #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .SerIn(SerIn), .SerValid(SerValid), .RdEn(RdEn),
    .RxData(RxData), .RxResult(RxResult), .RxFlag(RxFlag), .Empty(Empty),
    .Full(Full), .Count(Count), .RxBusy(RxBusy), .Overflow(Overflow), .FrameErr(FrameErr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; SerValid = 1'b0; SerIn = 1'b0; RdEn = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic pop();
    RdEn = 1'b1;
    tick();
    RdEn = 1'b0;
  endtask

  // Sends a frame MSB first with `gap` idle cycles between bits; optionally pops on the last bit
  task automatic send_frame(input logic [31:0] f, input int gap, input logic rd_last);
    for (int i = 31; i >= 0; i--) begin
      SerIn = f[i]; SerValid = 1'b1; RdEn = (i == 0) ? rd_last : 1'b0;
      tick();
      RdEn = 1'b0;
      if (RxBusy !== ((i > 0) ? 1'b1 : 1'b0)) busy_err++;
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          SerValid = 1'b0; SerIn = 1'($urandom);
          tick();
          if (RxBusy !== 1'b1) busy_err++;
        end
      end
    end
    SerValid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},    Empty,    1);
    check({tag, "_full"},     Full,     0);
    check({tag, "_count"},    Count,    0);
    check({tag, "_rxdata"},   RxData,   0);
    check({tag, "_rxresult"}, RxResult, 0);
    check({tag, "_rxflag"},   RxFlag,   0);
    check({tag, "_rxbusy"},   RxBusy,   0);
    check({tag, "_overflow"}, Overflow, 0);
    check({tag, "_frameerr"}, FrameErr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [31:0] q[$];
    logic [31:0] acc;
    int nb;
    logic exp_ovf;
    int rd_range;

    vecs[0] = '{32'h0000005A, 0, 8'h5A, 4'h0};
    vecs[1] = '{32'h01000000, 1, 8'h00, 4'h1};
    vecs[2] = '{32'hFFFFFFFF, 0, 8'hFF, 4'hF};
    vecs[3] = '{32'h0A0000C3, 2, 8'hC3, 4'hA};
    vecs[4] = '{32'h5F00A500, 0, 8'h00, 4'hF};
    vecs[5] = '{32'h80000001, 3, 8'h01, 4'h0};
    fr[0] = 32'h11000001; fr[1] = 32'h22000002; fr[2] = 32'h33000003;
    fr[3] = 32'h44000004; fr[4] = 32'h55000005;

    do_reset();
    check_reset_outputs("reset");

    // Single frames with various bit spacing, decoded fields and RxBusy span
    foreach (vecs[k]) begin
      busy_err = 0;
      send_frame(vecs[k].frame, vecs[k].gap, 1'b0);
      check($sformatf("vec%0d_empty", k),  Empty,    0);
      check($sformatf("vec%0d_count", k),  Count,    1);
      check($sformatf("vec%0d_data", k),   RxData,   vecs[k].frame);
      check($sformatf("vec%0d_result", k), RxResult, vecs[k].exp_result);
      check($sformatf("vec%0d_flag", k),   RxFlag,   vecs[k].exp_flag);
      check($sformatf("vec%0d_busy", k),   busy_err, 0);
      pop();
      check($sformatf("vec%0d_popempty", k), Empty, 1);
    end

    // Fill, overflow on the fifth frame, drain in order, then pop while empty
    for (int i = 0; i < 4; i++) send_frame(fr[i], 0, 1'b0);
    check("ovf_full", Full, 1);
    check("ovf_count4", Count, 4);
    send_frame(fr[4], 0, 1'b0);
    check("ovf_pulse", Overflow, 1);
    check("ovf_count_kept", Count, 4);
    tick();
    check("ovf_pulse_end", Overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_order%0d", i), RxData, fr[i]);
      pop();
    end
    check("ovf_drained", Empty, 1);
    pop();
    check("empty_pop_count", Count, 0);
    check("empty_pop_ovf", Overflow, 0);

    // Completion coinciding with a pop while full
    for (int i = 0; i < 4; i++) send_frame(fr[i], 0, 1'b0);
    send_frame(fr[4], 0, 1'b1);
    check("simul_no_ovf", Overflow, 0);
    check("simul_count", Count, 4);
    check("simul_full", Full, 1);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("simul_order%0d", i), RxData, fr[i]);
      pop();
    end
    check("simul_drained", Empty, 1);

    // Completion coinciding with a pop while empty
    send_frame(fr[2], 0, 1'b1);
    check("empty_simul_count", Count, 1);
    check("empty_simul_data", RxData, fr[2]);
    pop();

    // Partial frame followed by a long idle stretch
    do_reset();
    for (int i = 31; i >= 22; i--) begin
      SerIn = fr[3][i]; SerValid = 1'b1;
      tick();
    end
    SerValid = 1'b0;
    check("to_busy_partial", RxBusy, 1);
    pulses = 0;
    for (int c = 0; c < TIMEOUT + 2; c++) begin
      tick();
      if (FrameErr === 1'b1) pulses++;
    end
`ifdef SERIAL_RX_TIMEOUT_EN
    check("to_pulses", pulses, 1);
    check("to_busy_after", RxBusy, 0);
    send_frame(fr[1], 0, 1'b0);
    check("to_next_frame", RxData, fr[1]);
    check("to_next_count", Count, 1);
`else
    check("to_pulses", pulses, 0);
    check("to_busy_after", RxBusy, 1);
`endif

    // Reset mid-frame with frames stored
    do_reset();
    send_frame(fr[0], 0, 1'b0);
    send_frame(fr[1], 0, 1'b0);
    for (int i = 31; i >= 12; i--) begin
      SerIn = fr[2][i]; SerValid = 1'b1;
      tick();
    end
    SerValid = 1'b0; Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check_reset_outputs("midrst");
    send_frame(fr[3], 1, 1'b0);
    check("midrst_next_data", RxData, fr[3]);
    check("midrst_next_count", Count, 1);

    // Random traffic against a frame-queue reference
    do_reset();
    acc = '0;
    nb = 0;
    for (int c = 0; c < 3000; c++) begin
      rd_range = (c < 1500) ? 60 : 4;
      SerValid = ($urandom_range(0, 3) != 0);
      SerIn    = 1'($urandom);
      RdEn     = ($urandom_range(0, rd_range) == 0);
      exp_ovf  = 1'b0;
      if (RdEn && q.size() > 0) void'(q.pop_front());
      if (SerValid) begin
        acc = {acc[30:0], SerIn};
        nb++;
        if (nb == DW) begin
          nb = 0;
          if (q.size() < DEPTH) q.push_back(acc);
          else exp_ovf = 1'b1;
        end
      end
      tick();
      check("rnd_count", Count, q.size());
      check("rnd_empty", Empty, (q.size() == 0));
      check("rnd_full", Full, (q.size() == DEPTH));
      check("rnd_overflow", Overflow, exp_ovf);
      check("rnd_busy", RxBusy, (nb != 0));
      if (q.size() > 0) check("rnd_data", RxData, q[0]);
    end
    RdEn = 1'b0;
    SerValid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
